// File: rtl/card_dealer.sv
// Card dealer: fills four hand slots with blackjack card values drawn from a free-running LFSR.
// Latency: first card one cycle after the request, later cards CARD_DELAY+1 cycles apart; done the cycle after the last write.
// Backpressure: none; requests that arrive while busy are dropped. Optional totals logic under CARD_DEALER_TOTAL_EN.
module card_dealer #(
    parameter int unsigned CARD_DELAY = 100_000_000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       deal_pulse,
    input  logic       hit_pulse,
    output logic [3:0] first_card,
    output logic [3:0] second_card,
    output logic [3:0] third_card,
    output logic [3:0] fourth_card,
    output logic [2:0] card_count,
    output logic       busy,
    output logic       done
`ifdef CARD_DEALER_TOTAL_EN
    ,
    output logic [4:0] hand_total,
    output logic [0:0] bust
`endif
);

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    // The delay counter only ever holds CARD_DELAY-1 down to 0.
    localparam int unsigned CW = (CARD_DELAY > 1) ? $clog2(CARD_DELAY) : 1;
    localparam logic [CW-1:0] DELAY_LOAD = CW'(CARD_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    slot_q [4];
    logic [3:0]    slot_d [4];
    logic [2:0]    count_q, count_d;
    logic [2:0]    target_q, target_d;
    logic [CW-1:0] delay_q, delay_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          lfsr_fb;
    logic [3:0]    rank;
    logic          rank_ok;
    logic [3:0]    card_val;
    logic          deal_accept;

    // Rank draw: accept 1..13, face cards count as 10, everything else is retried next cycle.
    always_comb begin
        lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        rank     = lfsr_q[3:0];
        rank_ok  = (rank != 4'd0) && (rank <= 4'd13);
        card_val = (rank > 4'd10) ? 4'd10 : rank;
    end

    // Next-state logic for the request FSM, slots, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_fb};
        slot_d      = slot_q;
        count_d     = count_q;
        target_d    = target_q;
        delay_d     = delay_q;
        done_d      = 1'b0;
        deal_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (deal_pulse) begin
                    deal_accept = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        slot_d[i] = 4'd0;
                    end
                    count_d  = 3'd0;
                    target_d = 3'd2;
                    state_d  = S_DRAW;
                end else if (hit_pulse && (count_q == 3'd2 || count_q == 3'd3)) begin
                    target_d = count_q + 3'd1;
                    state_d  = S_DRAW;
                end
            end
            S_DRAW: begin
                if (count_q >= 3'd4) begin
                    // Hand already full: finish without touching any slot.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (rank_ok) begin
                    slot_d[count_q[1:0]] = card_val;
                    count_d              = count_q + 3'd1;
                    if (count_d == target_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        delay_d = DELAY_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (delay_q == '0) begin
                    state_d = S_DRAW;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef CARD_DEALER_TOTAL_EN
    logic [5:0] sum_raw;
    logic [5:0] total_full;
    logic       has_ace;
    logic       bust_q, bust_d;

    // Soft-ace hand value; the full 6-bit total drives bust, the port saturates at 31.
    always_comb begin
        sum_raw = 6'(slot_q[0]) + 6'(slot_q[1]) + 6'(slot_q[2]) + 6'(slot_q[3]);
        has_ace = (slot_q[0] == 4'd1) || (slot_q[1] == 4'd1) ||
                  (slot_q[2] == 4'd1) || (slot_q[3] == 4'd1);
        if (has_ace && (sum_raw + 6'd10 <= 6'd21)) begin
            total_full = sum_raw + 6'd10;
        end else begin
            total_full = sum_raw;
        end
        hand_total = (total_full > 6'd31) ? 5'd31 : total_full[4:0];
        bust_d     = deal_accept ? 1'b0 : (total_full > 6'd21);
    end

    // Bust flag follows the hand one cycle late and is cleared when a new hand starts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bust_q <= 1'b0;
        end else begin
            bust_q <= bust_d;
        end
    end

    assign bust = bust_q;
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED_EFF;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= 4'd0;
            end
            count_q  <= 3'd0;
            target_q <= 3'd0;
            delay_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q  <= count_d;
            target_q <= target_d;
            delay_q  <= delay_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign first_card  = slot_q[0];
    assign second_card = slot_q[1];
    assign third_card  = slot_q[2];
    assign fourth_card = slot_q[3];
    assign card_count  = count_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
